uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of byte-stream requesters sharing one UART transmitter (range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: consecutive idle cycles of the lock owner before the lock is force-released.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, NUM_REQ bits: per-requester byte valid.
REQ-006 SHALL have port req_data_i, input, NUM_REQ*8 bits: per-requester byte; requester k occupies bits [8k+7:8k].
REQ-007 SHALL have port req_ready_o, output, NUM_REQ bits: per-requester byte accept.
REQ-008 SHALL have port tx_valid_o, output, 1 bit: byte available to the UART serializer.
REQ-009 SHALL have port tx_data_o, output, 8 bits: byte to serialize.
REQ-010 SHALL have port tx_ready_i, input, 1 bit: serializer accepts the byte.
REQ-011 SHALL have port grant_o, output, NUM_REQ bits: one-hot current lock owner; all-zero when unlocked.
REQ-012 SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a lock is force-released.

Function
REQ-013 SHALL implement two states: IDLE (no owner) and LOCKED (one owner holds the line).
REQ-014 In IDLE, SHALL drive req_ready_o all-zero and select the first requester with req_valid_i high, searching upward from the round-robin pointer rr_ptr with wrap from NUM_REQ-1 to 0.
REQ-015 On a selection in IDLE, SHALL enter LOCKED on the next cycle, with grant_o one-hot for the selected requester from that cycle on; no byte is accepted in the selection cycle.
REQ-016 In LOCKED with owner k, SHALL drive req_ready_o[k] = (!tx_valid_o || tx_ready_i); all other req_ready_o bits SHALL be zero.
REQ-017 An accepted byte (req_valid_i[k] && req_ready_o[k]) SHALL appear on tx_data_o with tx_valid_o high in the next cycle: one-cycle latency, single output register, no byte reordering or duplication.
REQ-018 Once high, tx_valid_o and tx_data_o SHALL hold stable until the cycle in which tx_ready_i is high; tx_valid_o SHALL drop the following cycle unless a new byte is accepted in the same cycle.
REQ-019 Accepting byte 8'h0A from the owner SHALL release the lock: next state IDLE, grant_o all-zero, rr_ptr = (k+1) mod NUM_REQ; the newline byte itself is still presented on tx_data_o.
REQ-020 In LOCKED, an idle counter SHALL increment each cycle without an accepted byte and clear on every accepted byte; its width is $clog2(TIMEOUT_CYC+1).
REQ-021 When the idle counter reaches TIMEOUT_CYC-1 with no accept in that cycle, the block SHALL return to IDLE next cycle, set rr_ptr = (k+1) mod NUM_REQ and pulse timeout_o high for exactly that one cycle.
REQ-022 Newline accept and timeout cannot coincide, because an accept clears the counter; newline release takes precedence by construction.
REQ-023 A pending byte in the output register SHALL drain normally across a release and a new grant; the new owner's first byte is accepted only once the register is empty or draining (REQ-016).
REQ-024 Requesters dropping req_valid_i while not granted SHALL have no effect; an owner dropping req_valid_i mid-line SHALL keep the lock until newline or timeout.

Reset
REQ-025 While rst_i is high at a clock edge: state IDLE, rr_ptr 0, idle counter 0, tx_valid_o 0, tx_data_o 8'h00, grant_o 0, req_ready_o 0, timeout_o 0.
REQ-026 Reset asserted mid-operation SHALL discard any byte held in the output register without completing its handshake.

Verification
REQ-027 Req 1 sends "AB\n" with tx_ready_i tied high, NUM_REQ=4 -> grant_o=4'b0010 one cycle after request; tx_data_o 8'h41, 8'h42, 8'h0A on consecutive cycles; grant_o 0 after 8'h0A; rr_ptr=2.
REQ-028 Req 0 and req 2 both valid from reset -> req 0 sends "X\n" then req 2 gets the grant; req 0 re-requests -> served only after req 2's newline.
REQ-029 tx_ready_i low for 5 cycles with tx_valid_o high -> tx_data_o stable, req_ready_o[owner] 0 for those cycles; no byte lost or duplicated.
REQ-030 TIMEOUT_CYC=8, owner sends 8'h41 then goes idle -> timeout_o pulses 1 cycle after 8 idle cycles; grant moves to the next valid requester.
REQ-031 rst_i high for 1 cycle while tx_valid_o=1 and LOCKED -> next cycle tx_valid_o 0, grant_o 0; arbitration restarts from requester 0.
REQ-032 Random traffic on 4 requesters -> each requester's bytes appear on tx_data_o in order; no interleaving of two requesters between newlines unless a timeout_o pulse occurs.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin lock arbiter: NUM_REQ byte streams share one UART transmitter.
// A requester owns the line until its newline byte is accepted or it idles too long.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 timeout_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       NEWLINE   = 8'h0A;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             timeout_q, timeout_d;

    logic               locked;
    logic               slot_free;
    logic               accept;
    logic               owner_valid;
    logic [7:0]         owner_data;
    logic [NUM_REQ-1:0] owner_oh;
    logic [IDX_W-1:0]   next_ptr;

    logic [NUM_REQ-1:0] rot_valid;
    logic [IDX_W-1:0]   offset;
    logic [IDX_W:0]     sel_sum;
    logic [IDX_W-1:0]   sel_idx;
    logic               any_valid;

    assign locked    = (state_q == ST_LOCKED);
    assign slot_free = !tx_valid_q || tx_ready_i;
    assign accept    = locked && owner_valid && slot_free;
    assign next_ptr  = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = 8'h00;
        owner_oh    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_valid = req_valid_i[i];
                owner_data  = req_data_i[i*8 +: 8];
                owner_oh[i] = 1'b1;
            end
        end
    end

    // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit is the winner.
    always_comb begin
        rot_valid = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr_q);
        any_valid = |req_valid_i;
        offset    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                offset = IDX_W'(i);
            end
        end
        sel_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
        if (sel_sum >= NUM_REQ_W) begin
            sel_sum = sel_sum - NUM_REQ_W;
        end
        sel_idx = sel_sum[IDX_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        timeout_d  = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = owner_data;
        end else if (tx_ready_i) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (any_valid) begin
                    state_d = ST_LOCKED;
                    owner_d = sel_idx;
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    idle_cnt_d = '0;
                    if (owner_data == NEWLINE) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (idle_cnt_q == CNT_LAST) begin
                    // Owner went quiet: hand the line to the next requester.
                    state_d    = ST_IDLE;
                    rr_ptr_d   = next_ptr;
                    idle_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant_o     = locked ? owner_oh : '0;
    assign req_ready_o = (locked && slot_free) ? owner_oh : '0;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign timeout_o   = timeout_q;

endmodule
